// File: rtl/jt053245_pkg.sv
// jt053245_pkg
// Shared types and constants for the jt053245 sprite line drawer.
//   state_t  : drawer FSM states
//   ZOOM_ONE : 1.0 in 6.6 fixed point (unzoomed source step)
//   MAX_PIX  : ceiling on output pixels emitted per draw
package jt053245_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [11:0] ZOOM_ONE = 12'h040;
    localparam int          MAX_PIX  = 256;

    // 15 - n for a 4-bit index is its bitwise inverse
    function automatic logic [3:0] pix_index(input logic [3:0] src_int, input logic hflip);
        return hflip ? ~src_int : src_int;
    endfunction

endpackage

// File: rtl/jt053245_zstep.sv
// jt053245_zstep
// Combinational source-position stepper for the sprite line drawer.
// Ports:
//   src      in  10 : current source position, 4.6 fixed point
//   step     in  12 : source advance per output pixel, 6.6 fixed point
//   hflip    in   1 : horizontal flip
//   src_nxt  out 10 : src + step, truncated to 10 bits
//   pix      out  4 : ROM pixel index addressed by the current src
//   half_chg out  1 : the next src falls in the other 8-pixel ROM word
//   ovf      out  1 : the next src integer part runs past 15
module jt053245_zstep
    import jt053245_pkg::*;
(
    input  logic [9:0]  src,
    input  logic [11:0] step,
    input  logic        hflip,
    output logic [9:0]  src_nxt,
    output logic [3:0]  pix,
    output logic        half_chg,
    output logic        ovf
);

    logic [12:0] sum;

    always_comb begin
        sum      = {3'd0, src} + {1'b0, step};
        src_nxt  = sum[9:0];
        ovf      = |sum[12:10];
        pix      = pix_index(src[9:6], hflip);
        // flip inverts both halves alike, so only bit 9 of the position matters
        half_chg = src[9] ^ sum[9];
    end

endmodule

// File: rtl/jt053245_draw.sv
// jt053245_draw
// Sprite line drawer: fetches one 16-pixel 4bpp sprite row from graphics ROM,
// applies horizontal zoom/flip and writes opaque pixels to the line buffer.
// Optional feature macro: JT053245_DRAW_HZOOM_EN (horizontal zoom and phase
// carry-over). Without it the step is fixed at 1.0 and exactly 16 pixels go out.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   dr_start / dr_busy    : draw request pulse / drawer occupied
//   code, attr, hflip, vflip, hpos, ysub, hzoom, hz_keep : sprite row parameters
//   rom_addr, rom_cs      : ROM word request {code, row, half}
//   rom_ok, rom_data      : ROM word valid / eight 4bpp pixels
//   buf_addr, buf_din, buf_we : line-buffer write port, {attr, pixel}
//
// state | meaning
// IDLE  | waiting for dr_start
// FETCH | ROM request held until a fresh rom_ok
// DRAW  | one output pixel per clock from the latched word
// DONE  | one-cycle tail before returning to IDLE
module jt053245_draw
    import jt053245_pkg::*;
#(
    parameter int BW = 9
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          dr_start,
    input  logic [15:0]   code,
    input  logic [6:0]    attr,
    input  logic          hflip,
    input  logic          vflip,
    input  logic [9:0]    hpos,
    input  logic [3:0]    ysub,
    input  logic [11:0]   hzoom,
    input  logic          hz_keep,
    output logic          dr_busy,
    output logic [20:0]   rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [BW-1:0] buf_addr,
    output logic [10:0]   buf_din,
    output logic          buf_we
);

    state_t      state, state_nxt;
    logic [15:0] code_r;
    logic [6:0]  attr_r;
    logic        hflip_r;
    logic [3:0]  row_r, row_in;
    logic [9:0]  x;
    logic [3:0]  src_int;
    logic [7:0]  cnt;
    logic [31:0] word;
    logic        rom_wait;   // first cycle after a new rom_addr: rom_ok may be stale
    logic        cool;       // first IDLE cycle after DONE: requests are not taken yet
    logic [11:0] step;
    logic [9:0]  src_nxt;
    logic [3:0]  pix, pixel;
    logic        half_chg, ovf;
    logic        start_ok, fetch_ok, draw_end;

`ifdef JT053245_DRAW_HZOOM_EN
    logic [11:0] hzoom_r;
    logic [5:0]  src_frac;
    assign step = (hzoom_r == 12'd0) ? ZOOM_ONE : hzoom_r;
`else
    logic [5:0]  src_frac;
    logic        unused_zoom;
    assign src_frac    = 6'd0;
    assign step        = ZOOM_ONE;
    assign unused_zoom = ^{hzoom, hz_keep, src_nxt[5:0]};
`endif

    jt053245_zstep u_zstep (
        .src      ({src_int, src_frac}),
        .step     (step),
        .hflip    (hflip_r),
        .src_nxt  (src_nxt),
        .pix      (pix),
        .half_chg (half_chg),
        .ovf      (ovf)
    );

    assign row_in   = vflip ? ~ysub : ysub;
    assign pixel    = word[{pix[2:0], 2'b00} +: 4];
    assign start_ok = dr_start && !cool;
    assign fetch_ok = rom_ok && !rom_wait;
    assign draw_end = ovf || (cnt == 8'(MAX_PIX - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = FETCH;
            FETCH:   if (fetch_ok) state_nxt = DRAW;
            DRAW: begin
                if (draw_end)      state_nxt = DONE;
                else if (half_chg) state_nxt = FETCH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dr_busy = (state != IDLE);
        rom_cs  = (state == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            buf_addr <= '0;
            buf_din  <= '0;
            buf_we   <= 1'b0;
            rom_wait <= 1'b0;
            cool     <= 1'b0;
            src_int  <= '0;
            cnt      <= '0;
            x        <= '0;
`ifdef JT053245_DRAW_HZOOM_EN
            src_frac <= '0;
`endif
        end else begin
            cool     <= (state == DONE);
            buf_we   <= 1'b0;
            rom_wait <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    code_r   <= code;
                    attr_r   <= attr;
                    hflip_r  <= hflip;
                    row_r    <= row_in;
                    x        <= hpos;
                    cnt      <= '0;
                    src_int  <= '0;
                    rom_addr <= {code, row_in, hflip};
                    rom_wait <= 1'b1;
`ifdef JT053245_DRAW_HZOOM_EN
                    hzoom_r  <= hzoom;
                    if (!hz_keep) src_frac <= '0;
`endif
                end
                FETCH: if (fetch_ok) word <= rom_data;
                DRAW: begin
                    buf_addr <= x[BW-1:0];
                    buf_din  <= {attr_r, pixel};
                    buf_we   <= (pixel != 4'd0) && (x[9:BW] == '0);
                    x        <= x + 10'd1;
                    cnt      <= cnt + 8'd1;
                    src_int  <= src_nxt[9:6];
`ifdef JT053245_DRAW_HZOOM_EN
                    src_frac <= src_nxt[5:0];
`endif
                    if (!draw_end && half_chg) begin
                        rom_addr <= {code_r, row_r, ~pix[3]};
                        rom_wait <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt053245_draw.sv
module tb_jt053245_draw;

    logic        clk = 1'b0;
    logic        rst;
    logic        dr_start;
    logic [15:0] code;
    logic [6:0]  attr;
    logic        hflip, vflip;
    logic [9:0]  hpos;
    logic [3:0]  ysub;
    logic [11:0] hzoom;
    logic        hz_keep;
    logic        dr_busy;
    logic [20:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [10:0] buf_din;
    logic        buf_we;

    int tests = 0;
    int fails = 0;

    logic        rom_dir  = 1'b1;  // directed ROM image: nibbles 1..8 / 9..F,0
    logic        rom_rand = 1'b0;  // random ROM latency
    logic        stall    = 1'b0;
    int          mfrac    = 0;     // model's carried source fraction

    logic [19:0] wq[$];            // expected writes {addr, attr, pixel}
    logic [20:0] fq[$];            // expected fetch addresses

    always #5 clk = ~clk;

    jt053245_draw #(.BW(9)) dut (
        .clk(clk), .rst(rst), .dr_start(dr_start), .code(code), .attr(attr),
        .hflip(hflip), .vflip(vflip), .hpos(hpos), .ysub(ysub), .hzoom(hzoom),
        .hz_keep(hz_keep), .dr_busy(dr_busy), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_ok(rom_ok), .rom_data(rom_data), .buf_addr(buf_addr), .buf_din(buf_din),
        .buf_we(buf_we)
    );

    function automatic logic [31:0] rom_word(input logic [20:0] a);
        logic [31:0] h;
        if (rom_dir) return a[0] ? 32'h0FEDCBA9 : 32'h87654321;
        h = 32'(a) * 32'h9E3779B1;
        return h ^ (h >> 15);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Reference model: walk the source position arithmetically, one output pixel at a time.
    task automatic issue(input logic [15:0] c, input logic [6:0] a, input logic hf, input logic vf,
                         input logic [9:0] hp, input logic [3:0] ys, input logic [11:0] hz,
                         input logic keep);
        int stp, s, n, idx, phys, half, prev_half, xx;
        logic [3:0]  row;
        logic [20:0] ad;
        logic [31:0] w;
        logic [3:0]  p;
        row = vf ? 4'(15 - int'(ys)) : ys;
`ifdef JT053245_DRAW_HZOOM_EN
        stp = (hz == 12'd0) ? 64 : int'(hz);
        s   = keep ? mfrac : 0;
`else
        stp = 64;
        s   = 0;
`endif
        n = 0;
        prev_half = -1;
        do begin
            idx  = s / 64;
            phys = hf ? 15 - idx : idx;
            half = phys / 8;
            ad   = {c, row, 1'(half)};
            if (half != prev_half) fq.push_back(ad);
            prev_half = half;
            w  = rom_word(ad);
            p  = 4'((w >> (4 * (phys % 8))) & 32'hF);
            xx = (int'(hp) + n) % 1024;
            if (p != 4'd0 && xx < 512) wq.push_back({9'(xx), a, p});
            n++;
            s += stp;
        end while (s < 1024 && n < 256);
        mfrac = s % 64;

        code = c; attr = a; hflip = hf; vflip = vf; hpos = hp; ysub = ys;
        hzoom = hz; hz_keep = keep;
        dr_start = 1'b1;
        @(posedge clk); #1;
        dr_start = 1'b0;
        // inputs must have been latched; scramble them
        code = 16'($urandom); attr = 7'($urandom); hflip = 1'($urandom); vflip = 1'($urandom);
        hpos = 10'($urandom); ysub = 4'($urandom); hzoom = 12'($urandom); hz_keep = 1'($urandom);
    endtask

    task automatic drain_check();
        check("write_queue_drained", 64'(wq.size()), 64'd0);
        check("fetch_queue_drained", 64'(fq.size()), 64'd0);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!dr_busy) break;
        end
        if (k == 3000) report_fail("busy_timeout", 64'(dr_busy));
        drain_check();
        @(posedge clk); #1;
    endtask

    // ROM responder
    initial begin
        rom_ok = 1'b0;
        rom_data = '0;
        forever begin
            @(negedge clk);
            rom_data = rom_word(rom_addr);
            rom_ok = rom_cs && !stall && (!rom_rand || ($urandom_range(0, 2) != 0));
        end
    end

    // write monitor
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (!rst && buf_we) begin
                if (wq.size() == 0) report_fail("write_extra", {buf_addr, buf_din});
                else begin
                    e = wq.pop_front();
                    check("write_addr", 64'(buf_addr), 64'(e[19:11]));
                    check("write_din",  64'(buf_din),  64'(e[10:0]));
                end
            end
        end
    end

    // fetch monitor: every rising rom_cs starts a new fetch
    initial begin
        logic cs_prev;
        logic [20:0] e;
        cs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) cs_prev = 1'b0;
            else begin
                if (rom_cs && !cs_prev) begin
                    if (fq.size() == 0) report_fail("fetch_extra", 64'(rom_addr));
                    else begin
                        e = fq.pop_front();
                        check("fetch_addr", 64'(rom_addr), 64'(e));
                    end
                end
                cs_prev = rom_cs;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int first, cyc;
        logic [11:0] hz;
        rst = 1'b1; dr_start = 1'b0; code = '0; attr = '0; hflip = 1'b0; vflip = 1'b0;
        hpos = '0; ysub = '0; hzoom = '0; hz_keep = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(dr_busy), 64'd0);
        check("rst_rom_cs", 64'(rom_cs), 64'd0);
        check("rst_buf_we", 64'(buf_we), 64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_buf_addr", 64'(buf_addr), 64'd0);
        check("rst_buf_din", 64'(buf_din), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed unzoomed row with latency checks
        issue(16'h1234, 7'h15, 1'b0, 1'b0, 10'd100, 4'd5, 12'h040, 1'b0);
        first = -1;
        cyc = 0;
        repeat (100) begin
            @(posedge clk); #1;
            cyc++;
            if (buf_we && first < 0) first = cyc;
            if (!dr_busy) break;
        end
        check("first_write_latency", 64'(first), 64'd3);
        check("busy_duration_20_23", 64'(cyc >= 20 && cyc <= 23), 64'd1);
        drain_check();
        @(posedge clk); #1;

        // flipped both ways
        issue(16'h1234, 7'h2A, 1'b1, 1'b1, 10'd100, 4'd5, 12'h040, 1'b0);
        wait_idle();

        // zoom out / zoom in
        issue(16'h0BEE, 7'h01, 1'b0, 1'b0, 10'd40, 4'd3, 12'h080, 1'b0);
        wait_idle();
        issue(16'h0BEE, 7'h02, 1'b0, 1'b0, 10'd200, 4'd3, 12'h020, 1'b0);
        wait_idle();

        // right edge clip
        issue(16'h0042, 7'h33, 1'b0, 1'b0, 10'h1FC, 4'd0, 12'h040, 1'b0);
        wait_idle();

        // stalled ROM with a request while busy
        rom_dir = 1'b0;
        stall = 1'b1;
        issue(16'h5A5A, 7'h44, 1'b0, 1'b0, 10'd7, 4'd9, 12'h040, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_busy", 64'(dr_busy), 64'd1);
        check("stall_rom_cs", 64'(rom_cs), 64'd1);
        code = 16'hDEAD; hpos = 10'd300;
        dr_start = 1'b1;
        @(posedge clk); #1;
        dr_start = 1'b0;
        stall = 1'b0;
        wait_idle();

        // request on the cycle busy falls is ignored, next cycle accepted
        issue(16'h0777, 7'h55, 1'b1, 1'b0, 10'd0, 4'd1, 12'h040, 1'b0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!dr_busy) break;
        end
        dr_start = 1'b1;
        @(posedge clk); #1;
        dr_start = 1'b0;
        check("start_at_fall_ignored", 64'(dr_busy), 64'd0);
        drain_check();
        issue(16'h0778, 7'h56, 1'b0, 1'b1, 10'd20, 4'd2, 12'h040, 1'b0);
        check("start_after_fall_taken", 64'(dr_busy), 64'd1);
        wait_idle();

        // reset mid-DRAW
        issue(16'h3333, 7'h66, 1'b0, 1'b0, 10'd50, 4'd4, 12'h040, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(dr_busy), 64'd0);
        check("midrst_we", 64'(buf_we), 64'd0);
        check("midrst_cs", 64'(rom_cs), 64'd0);
        check("midrst_outs", 64'({rom_addr, buf_addr, buf_din}), 64'd0);
        rst = 1'b0;
        wq.delete();
        fq.delete();
        mfrac = 0;
        @(posedge clk); #1;

        // fractional step with phase carried into the next draw
        issue(16'h0101, 7'h11, 1'b0, 1'b0, 10'd60, 4'd6, 12'h030, 1'b0);
        wait_idle();
        issue(16'h0102, 7'h12, 1'b0, 1'b0, 10'd90, 4'd6, 12'h030, 1'b1);
        wait_idle();

        // randomized draws with random ROM latency
        rom_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            hz = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                             : 12'($urandom_range(0, 256));
            issue(16'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), 10'($urandom),
                  4'($urandom), hz, 1'($urandom));
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
